fp_div_normalizer: RTL and testbench

FP_DIV_NORMALIZER -- requirements
Module: fp_div_normalizer

---
 rtl/fp_div_pkg.sv | 32 +++
 rtl/fp_round_rne.sv | 32 +++
 rtl/fp_div_normalizer.sv | 170 +++++++++++++++++
 tb/tb_fp_div_normalizer.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/fp_div_pkg.sv
// -----------------------------------------------------------------------------
// fp_div_pkg
// Shared definitions for the divider-output normalizer: FSM state encoding,
// IEEE-754 single-precision field widths, internal exponent width and a helper
// that assembles a packed single-precision word.
// -----------------------------------------------------------------------------
package fp_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_NORM  = 2'd1,
        ST_ROUND = 2'd2,
        ST_PACK  = 2'd3
    } state_t;

    localparam int EXP_BIAS = 127;
    localparam int EXP_MAX  = 255;
    localparam int MANT_W   = 24;   // significand width including hidden bit
    localparam int EXP_W    = 8;    // packed exponent field width
    localparam int IEXP_W   = 12;   // internal signed exponent width
    localparam int EXP_IN_W = 10;   // width of the incoming exponent difference

    // Assemble {sign, exponent, fraction} into a single-precision word.
    function automatic logic [31:0] pack_fp(
        input logic              sign,
        input logic [EXP_W-1:0]  exp_field,
        input logic [MANT_W-2:0] frac_field
    );
        return {sign, exp_field, frac_field};
    endfunction

endpackage

// File: rtl/fp_round_rne.sv
// -----------------------------------------------------------------------------
// fp_round_rne
// Combinational round-to-nearest-even on a 24-bit significand.
//   mant_in  : significand before rounding (hidden bit is mant_in[23])
//   guard    : first bit below the significand LSB
//   rnd      : second bit below the significand LSB
//   sticky   : OR of every lower discarded bit
//   frac_out : rounded 23-bit fraction (hidden bit dropped)
//   carry    : rounding overflowed 24 bits; exponent must be incremented
// -----------------------------------------------------------------------------
module fp_round_rne
    import fp_div_pkg::*;
(
    input  logic [MANT_W-1:0] mant_in,
    input  logic              guard,
    input  logic              rnd,
    input  logic              sticky,
    output logic [MANT_W-2:0] frac_out,
    output logic              carry
);

    logic inc_s;

    // Increment when above half, or exactly half with an odd significand.
    assign inc_s = guard & (rnd | sticky | mant_in[0]);

    // An all-ones significand plus one overflows; the 23-bit fraction then
    // wraps to zero, which is exactly the 0x800000 significand after the carry.
    assign carry    = inc_s & (&mant_in);
    assign frac_out = mant_in[MANT_W-2:0] + {{(MANT_W-2){1'b0}}, inc_s};

endmodule

// File: rtl/fp_div_normalizer.sv
// -----------------------------------------------------------------------------
// fp_div_normalizer
// Turns an integer divider's quotient/remainder into an IEEE-754 single.
// The quotient is normalized one bit per cycle so that bit FRAC_POS is the
// leading one, then rounded (RNE) and packed with overflow to infinity and
// flush-to-zero on underflow.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   div_ready  : divider done level; a rising edge in IDLE starts an operation
//   q_in, r_in : quotient and remainder (remainder only feeds sticky)
//   sign_in    : result sign
//   exp_in     : signed biased exponent difference (10 bits)
//   result     : packed single-precision result, held between valid pulses
//   valid      : one-cycle pulse when result updates
//   busy       : high whenever an operation is in flight
// -----------------------------------------------------------------------------
module fp_div_normalizer
    import fp_div_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int FRAC_POS = 26
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                div_ready,
    input  logic [WIDTH-1:0]    q_in,
    input  logic [WIDTH-1:0]    r_in,
    input  logic                sign_in,
    input  logic [EXP_IN_W-1:0] exp_in,
    output logic [31:0]         result,
    output logic                valid,
    output logic                busy
);

    // Positions of the guard, round and top sticky bits below the significand.
    localparam int G_POS = FRAC_POS - MANT_W;
    localparam int R_POS = FRAC_POS - MANT_W - 1;
    localparam int S_TOP = FRAC_POS - MANT_W - 2;

    localparam logic signed [IEXP_W-1:0] E_ZERO  = '0;
    localparam logic signed [IEXP_W-1:0] E_ONE   = IEXP_W'(1);
    localparam logic signed [IEXP_W-1:0] E_MAX_S = IEXP_W'(EXP_MAX);

    state_t                    state_r, next_state_s;
    logic [WIDTH-1:0]          w_r, w_nxt_s;
    logic signed [IEXP_W-1:0]  e_r, e_nxt_s;
    logic                      s_r, s_nxt_s;
    logic                      sticky_r, sticky_nxt_s;
    logic [MANT_W-2:0]         frac_r, frac_nxt_s;
    logic [31:0]               result_r, result_nxt_s;
    logic                      valid_r;
    logic                      busy_r;
    logic                      dr_prev_r;

    logic                      start_s;
    logic                      w_high_s;
    logic                      rnd_sticky_s;
    logic [MANT_W-2:0]         rnd_frac_s;
    logic                      rnd_carry_s;

    assign start_s      = div_ready & ~dr_prev_r;
    assign w_high_s     = (w_r[WIDTH-1:FRAC_POS+1] != '0);
    assign rnd_sticky_s = sticky_r | (|w_r[S_TOP:0]);

    fp_round_rne u_round (
        .mant_in  (w_r[FRAC_POS -: MANT_W]),
        .guard    (w_r[G_POS]),
        .rnd      (w_r[R_POS]),
        .sticky   (rnd_sticky_s),
        .frac_out (rnd_frac_s),
        .carry    (rnd_carry_s)
    );

    // Next-state and datapath update for the normalize/round/pack sequence.
    always_comb begin
        next_state_s = state_r;
        w_nxt_s      = w_r;
        e_nxt_s      = e_r;
        s_nxt_s      = s_r;
        sticky_nxt_s = sticky_r;
        frac_nxt_s   = frac_r;
        result_nxt_s = result_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    w_nxt_s      = q_in;
                    e_nxt_s      = {{(IEXP_W-EXP_IN_W){exp_in[EXP_IN_W-1]}}, exp_in};
                    s_nxt_s      = sign_in;
                    sticky_nxt_s = (r_in != '0);
                    next_state_s = ST_NORM;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_NORM: begin
                if (w_high_s) begin
                    w_nxt_s      = w_r >> 1;
                    sticky_nxt_s = sticky_r | w_r[0];
                    e_nxt_s      = e_r + E_ONE;
                end else if (w_r == '0) begin
                    // Zero exponent makes PACK emit a signed zero.
                    e_nxt_s      = E_ZERO;
                    next_state_s = ST_PACK;
                end else if (!w_r[FRAC_POS]) begin
                    w_nxt_s      = w_r << 1;
                    e_nxt_s      = e_r - E_ONE;
                end else begin
                    next_state_s = ST_ROUND;
                end
            end
            ST_ROUND: begin
                frac_nxt_s   = rnd_frac_s;
                sticky_nxt_s = rnd_sticky_s;
                if (rnd_carry_s) begin
                    e_nxt_s = e_r + E_ONE;
                end else begin
                    e_nxt_s = e_r;
                end
                next_state_s = ST_PACK;
            end
            ST_PACK: begin
                if (e_r >= E_MAX_S) begin
                    result_nxt_s = pack_fp(s_r, 8'hFF, 23'h000000);
                end else if (e_r <= E_ZERO) begin
                    result_nxt_s = {s_r, 31'h00000000};
                end else begin
                    result_nxt_s = pack_fp(s_r, e_r[EXP_W-1:0], frac_r);
                end
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State, datapath and output registers; reset aborts any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            w_r       <= '0;
            e_r       <= E_ZERO;
            s_r       <= 1'b0;
            sticky_r  <= 1'b0;
            frac_r    <= '0;
            result_r  <= 32'h00000000;
            valid_r   <= 1'b0;
            busy_r    <= 1'b0;
            // Treat div_ready as already high so a level held through reset
            // does not look like a fresh edge.
            dr_prev_r <= 1'b1;
        end else begin
            state_r   <= next_state_s;
            w_r       <= w_nxt_s;
            e_r       <= e_nxt_s;
            s_r       <= s_nxt_s;
            sticky_r  <= sticky_nxt_s;
            frac_r    <= frac_nxt_s;
            result_r  <= result_nxt_s;
            valid_r   <= (state_r == ST_PACK);
            busy_r    <= (next_state_s != ST_IDLE);
            dr_prev_r <= div_ready;
        end
    end

    assign result = result_r;
    assign valid  = valid_r;
    assign busy   = busy_r;

endmodule

// File: tb/tb_fp_div_normalizer.sv
// -----------------------------------------------------------------------------
// tb_fp_div_normalizer
// Directed self-checking bench for fp_div_normalizer with hand-computed
// expected results and latencies.
// -----------------------------------------------------------------------------
module tb_fp_div_normalizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_ready;
    logic [63:0] q_in;
    logic [63:0] r_in;
    logic        sign_in;
    logic [9:0]  exp_in;
    logic [31:0] result;
    logic        valid;
    logic        busy;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    fp_div_normalizer #(.WIDTH(64), .FRAC_POS(26)) dut (
        .clk       (clk),
        .rst       (rst),
        .div_ready (div_ready),
        .q_in      (q_in),
        .r_in      (r_in),
        .sign_in   (sign_in),
        .exp_in    (exp_in),
        .result    (result),
        .valid     (valid),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Launch one operation, wait for valid, check result, latency, pulse width and hold.
    task automatic run_op(input string tag, input logic [63:0] q, input logic [63:0] r,
                          input logic s, input logic [9:0] e,
                          input logic [31:0] exp_res, input int exp_lat);
        int lat;
        bit got;
        @(negedge clk);
        q_in = q; r_in = r; sign_in = s; exp_in = e; div_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, " busy_after_capture"}, 64'(busy), 64'd1);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 60) begin
            @(posedge clk); #1;
            lat++;
            if (valid === 1'b1) got = 1'b1;
        end
        check({tag, " valid_seen"}, 64'(got), 64'd1);
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " result"}, 64'(result), 64'(exp_res));
        @(negedge clk);
        div_ready = 1'b0;
        @(posedge clk); #1;
        check({tag, " valid_one_cycle"}, 64'(valid), 64'd0);
        check({tag, " busy_idle"}, 64'(busy), 64'd0);
        check({tag, " result_hold"}, 64'(result), 64'(exp_res));
    endtask

    initial begin
        int pulses;
        int busy_seen;
        logic [31:0] last_res;

        rst = 1'b1; div_ready = 1'b0; q_in = '0; r_in = '0; sign_in = 1'b0; exp_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset result", 64'(result), 64'd0);
        check("reset valid",  64'(valid),  64'd0);
        check("reset busy",   64'(busy),   64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("norm_1p5",     64'h6000000, 64'd0, 1'b0, 10'd127, 32'h3FC00000, 3);
        run_op("left_roundup", 64'h2AAAAAA, 64'd5, 1'b0, 10'd127, 32'h3F2AAAAB, 4);
        run_op("right_shift",  64'h8000000, 64'd0, 1'b0, 10'd127, 32'h40000000, 4);
        run_op("overflow_inf", 64'h8000000, 64'd0, 1'b0, 10'd254, 32'h7F800000, 4);
        run_op("neg_inf",      64'h8000000, 64'd0, 1'b1, 10'd254, 32'hFF800000, 4);
        run_op("round_carry",  64'h7FFFFFC, 64'd0, 1'b0, 10'd127, 32'h40000000, 3);
        run_op("flush_zero",   64'h4000000, 64'd0, 1'b0, 10'd0,   32'h00000000, 3);
        run_op("signed_zero",  64'h0,       64'd0, 1'b1, 10'd127, 32'h80000000, 2);

        // Second div_ready edge while busy must be ignored.
        @(negedge clk);
        q_in = 64'h8000000; r_in = '0; sign_in = 1'b0; exp_in = 10'd127; div_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        div_ready = 1'b0; q_in = 64'h6000000;
        @(negedge clk);
        div_ready = 1'b1;
        pulses = 0;
        last_res = '0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (valid === 1'b1) begin
                pulses++;
                last_res = result;
            end
        end
        check("ignored_edge pulses", 64'(pulses), 64'd1);
        check("ignored_edge result", 64'(last_res), 64'h40000000);
        @(negedge clk);
        div_ready = 1'b0;
        @(posedge clk);

        // Reset mid-NORM with div_ready held high: abort, no restart.
        @(negedge clk);
        q_in = 64'h1; r_in = '0; sign_in = 1'b0; exp_in = 10'd127; div_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort busy",   64'(busy),   64'd0);
        check("abort valid",  64'(valid),  64'd0);
        check("abort result", 64'(result), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        busy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (valid === 1'b1) pulses++;
            if (busy === 1'b1) busy_seen++;
        end
        check("no_restart valid", 64'(pulses),    64'd0);
        check("no_restart busy",  64'(busy_seen), 64'd0);
        @(negedge clk);
        div_ready = 1'b0;
        @(posedge clk);
        // Quotient 1 needs 26 left shifts: exponent 127-26 = 101.
        run_op("restart_q1", 64'h1, 64'd0, 1'b0, 10'd127, 32'h32800000, 29);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
